figure_state_reg: RTL and testbench
===================================

Name: figure_state_reg

Overview:
- Sequential stage directly downstream of control_fsm.
- Holds the falling figure's four cell coordinates (rho_x/rho_y) and the per-column surface (border), and feeds both back to control_fsm.
- Applies an accepted action when control_fsm grants it (is_move), spawns figures (is_load_fig), and commits a landed figure into the board, one cell per cycle, through a memory write port.

Parameters:
- WIDTH, 8, bit width of one coordinate / border entry
- MEM_WIDTH, 10, board columns
- MEM_HEIGHT, 20, board rows; border value meaning "column empty"
- SPAWN_X, 4, column of a newly spawned vertical figure

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- act_valid  in  1  one-cycle strobe: action/is_move/is_load_fig are valid this cycle
- action  in  WIDTH  0=load, 1=down, 2=left, 3=right, 4=rotR
- is_move  in  1  from control_fsm: requested move is legal
- is_load_fig  in  1  from control_fsm: load request
- rho_x  out  4*WIDTH  cell x coordinates; cell0 in [4W-1:3W], cell3 in [W-1:0]
- rho_y  out  4*WIDTH  cell y coordinates, same packing
- border  out  MEM_WIDTH*WIDTH  topmost occupied row per column; col0 in MSB slice; MEM_HEIGHT = empty
- busy  out  1  high in COMMIT; act_valid ignored while high
- mem_we  out  1  board write enable, one cycle per committed cell
- mem_x, mem_y  out  WIDTH each  board write address
- land_done  out  1  one-cycle pulse after the last committed cell
- game_over  out  1  sticky until reset

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE
  - all rho_x=0, all rho_y=0
  - every border entry=MEM_HEIGHT
  - busy=0, mem_we=0, mem_x=0, mem_y=0, land_done=0, game_over=0
- States: IDLE (no figure), ACTIVE, COMMIT (2-bit cell index k), OVER.
- IDLE:
  - act_valid & is_load_fig → spawn vertical: x[i]=SPAWN_X, y[i]=i.
  - If border[SPAWN_X] <= 3, go to OVER and set game_over; otherwise go to ACTIVE.
  - Spawn takes effect on the next edge.
  - Any other action is ignored.
- ACTIVE, act_valid high; all updates are registered, 1-cycle latency:
  - down & is_move: y[i]+=1.
  - down & !is_move: land; go to COMMIT with k=0, busy=1 from the next cycle.
  - left & is_move: x[i]-=1. right & is_move: x[i]+=1.
  - rotR & is_move, vertical (x0==x3): x[i]=x[i]+(3-i); y[i]=y3.
  - rotR & is_move, horizontal: x[i]=x0; y[i]=y0+i.
  - left/right/rotR with is_move=0: no change.
  - action 0 and codes >4: ignored.
- COMMIT, one cell per cycle, k=0..3:
  - mem_we=1, mem_x=x[k], mem_y=y[k].
  - border[x[k]] = min(border[x[k]], y[k]), updated on the same edge; later cells see earlier updates.
  - At k=3: land_done pulses in the following cycle and state goes to IDLE.
  - busy=1 throughout; act_valid is ignored (no queueing).
  - rho_x/rho_y hold their values.
- OVER: all inputs ignored; only reset exits.
- Arithmetic:
  - Coordinates are unsigned, WIDTH bits, mod 2^WIDTH.
  - No bounds checking: legality is control_fsm's responsibility.
  - Every border index is x[k] truncated to the column range; x[k] >= MEM_WIDTH is not written (defensive).
- Boundaries:
  - Reset asserted mid-COMMIT discards the partial commit and restores border to empty.
  - act_valid held high for several cycles is processed once per cycle.
  - A landing on the surface at row 0 still commits; game_over is decided only at the next spawn.

Decomposition:
- Shared package tetris_pkg holds:
  - action codes (ACT_LOAD..ACT_ROTR)
  - state enum (IDLE/ACTIVE/COMMIT/OVER)
  - MEM_WIDTH, MEM_HEIGHT, SPAWN_X
  - coordinate pack/unpack helpers for the 4*WIDTH buses
- One natural sub-module: figure_next, a combinational block mapping (action, x[], y[]) to next x[], y[]. It is shared verbatim for move/rotate math and unit-tested alone.

Test Plan:
- Reset, then load (act_valid, action=0, is_load_fig=1) → next cycle rho_x=all 4, rho_y={0,1,2,3}, border all 20.
- From spawn, down with is_move=1 three times → rho_y={3,4,5,6}. Then right, is_move=1 → rho_x all 5.
- Vertical at x=2, y={5,6,7,8}, rotR, is_move=1 → rho_x={5,4,3,2}, rho_y all 8. rotR again → rho_x all 5, rho_y={8,9,10,11}.
- Vertical at x=0, y={16..19}, down, is_move=0:
  - 4 consecutive mem_we pulses at (0,16),(0,17),(0,18),(0,19).
  - border[0]=16; land_done one cycle after the 4th write.
  - An act_valid applied during busy has no effect.
- Stack vertical figures in column 4 until border[4]=3, then load → game_over=1. Further loads → no change.
- Assert rst_n low during the second COMMIT cycle → border all 20 and state IDLE immediately; mem_we=0.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared definitions for the falling-figure datapath: action codes, FSM states,
// board geometry and helpers for the packed four-cell coordinate buses.
package tetris_pkg;

    localparam int WIDTH      = 8;
    localparam int MEM_WIDTH  = 10;
    localparam int MEM_HEIGHT = 20;
    localparam int SPAWN_X    = 4;
    localparam int COL_W      = $clog2(MEM_WIDTH);

    localparam logic [WIDTH-1:0] ACT_LOAD  = 8'd0;
    localparam logic [WIDTH-1:0] ACT_DOWN  = 8'd1;
    localparam logic [WIDTH-1:0] ACT_LEFT  = 8'd2;
    localparam logic [WIDTH-1:0] ACT_RIGHT = 8'd3;
    localparam logic [WIDTH-1:0] ACT_ROTR  = 8'd4;

    typedef logic [WIDTH-1:0]      coord_t;
    typedef logic [3:0][WIDTH-1:0] cells_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_COMMIT,
        ST_OVER
    } state_e;

    // Cell 0 occupies the most significant slice of the external bus.
    function automatic logic [4*WIDTH-1:0] pack_cells(input cells_t c);
        logic [4*WIDTH-1:0] r;
        for (int i = 0; i < 4; i++) r[(3-i)*WIDTH +: WIDTH] = c[i];
        return r;
    endfunction

    function automatic cells_t unpack_cells(input logic [4*WIDTH-1:0] v);
        cells_t c;
        for (int i = 0; i < 4; i++) c[i] = v[(3-i)*WIDTH +: WIDTH];
        return c;
    endfunction

endpackage

// File: rtl/figure_next.sv
// Combinational move/rotate math: maps an action and the current cell
// coordinates to the coordinates the figure would occupy afterwards.
module figure_next
    import tetris_pkg::*;
(
    input  logic [WIDTH-1:0] action,
    input  cells_t           x_i,
    input  cells_t           y_i,
    output cells_t           x_o,
    output cells_t           y_o
);

    always_comb begin
        // NOTE: default every output first so no path through the case infers a latch.
        x_o = x_i;
        y_o = y_i;
        case (action)
            ACT_DOWN:  for (int i = 0; i < 4; i++) y_o[i] = y_i[i] + coord_t'(1);
            ACT_LEFT:  for (int i = 0; i < 4; i++) x_o[i] = x_i[i] - coord_t'(1);
            ACT_RIGHT: for (int i = 0; i < 4; i++) x_o[i] = x_i[i] + coord_t'(1);
            ACT_ROTR: begin
                if (x_i[0] == x_i[3]) begin
                    // Vertical pivots about its bottom cell into a row.
                    for (int i = 0; i < 4; i++) begin
                        x_o[i] = x_i[i] + coord_t'(3 - i);
                        y_o[i] = y_i[3];
                    end
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        x_o[i] = x_i[0];
                        y_o[i] = y_i[0] + coord_t'(i);
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/figure_state_reg.sv
// Holds the falling figure and per-column surface, applies granted moves,
// spawns figures and commits a landed figure to the board one cell per cycle.
module figure_state_reg
    import tetris_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       act_valid,
    input  logic [WIDTH-1:0]           action,
    input  logic                       is_move,
    input  logic                       is_load_fig,
    output logic [4*WIDTH-1:0]         rho_x,
    output logic [4*WIDTH-1:0]         rho_y,
    output logic [MEM_WIDTH*WIDTH-1:0] border,
    output logic                       busy,
    output logic                       mem_we,
    output logic [WIDTH-1:0]           mem_x,
    output logic [WIDTH-1:0]           mem_y,
    output logic                       land_done,
    output logic                       game_over
);

    state_e                      state_q, state_d;
    logic [1:0]                  k_q, k_d;
    cells_t                      x_q, x_d, y_q, y_d;
    coord_t [MEM_WIDTH-1:0]      border_q, border_d;
    logic                        busy_q, busy_d;
    logic                        mem_we_q, mem_we_d;
    coord_t                      mem_x_q, mem_x_d, mem_y_q, mem_y_d;
    logic                        land_done_q, land_done_d;
    logic                        game_over_q, game_over_d;

    cells_t                      x_nx, y_nx;
    coord_t                      cur_x, cur_y;
    logic [COL_W-1:0]            col;
    logic [1:0]                  nk;

    figure_next u_next (
        .action (action),
        .x_i    (x_q),
        .y_i    (y_q),
        .x_o    (x_nx),
        .y_o    (y_nx)
    );

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        x_d         = x_q;
        y_d         = y_q;
        border_d    = border_q;
        mem_we_d    = 1'b0;
        mem_x_d     = mem_x_q;
        mem_y_d     = mem_y_q;
        land_done_d = 1'b0;
        game_over_d = game_over_q;
        cur_x       = x_q[k_q];
        cur_y       = y_q[k_q];
        col         = cur_x[COL_W-1:0];
        nk          = k_q + 2'd1;

        case (state_q)
            ST_IDLE: begin
                if (act_valid && is_load_fig) begin
                    for (int i = 0; i < 4; i++) begin
                        x_d[i] = coord_t'(SPAWN_X);
                        y_d[i] = coord_t'(i);
                    end
                    if (border_q[SPAWN_X] <= coord_t'(3)) begin
                        state_d     = ST_OVER;
                        game_over_d = 1'b1;
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end
            end
            ST_ACTIVE: begin
                if (act_valid) begin
                    if (action == ACT_DOWN && !is_move) begin
                        state_d  = ST_COMMIT;
                        k_d      = 2'd0;
                        mem_we_d = 1'b1;
                        mem_x_d  = x_q[0];
                        mem_y_d  = y_q[0];
                    end else if (is_move) begin
                        x_d = x_nx;
                        y_d = y_nx;
                    end
                end
            end
            ST_COMMIT: begin
                // Off-board columns are skipped rather than aliased onto a real column.
                if (cur_x < coord_t'(MEM_WIDTH) && cur_y < border_q[col])
                    border_d[col] = cur_y;
                if (k_q == 2'd3) begin
                    state_d     = ST_IDLE;
                    k_d         = 2'd0;
                    land_done_d = 1'b1;
                end else begin
                    k_d      = nk;
                    mem_we_d = 1'b1;
                    mem_x_d  = x_q[nk];
                    mem_y_d  = y_q[nk];
                end
            end
            default: ;
        endcase

        busy_d = (state_d == ST_COMMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            k_q         <= 2'd0;
            x_q         <= '0;
            y_q         <= '0;
            // NOTE: the surface array is reset because "empty column" is a real value, not don't-care.
            for (int c = 0; c < MEM_WIDTH; c++) border_q[c] <= coord_t'(MEM_HEIGHT);
            busy_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_x_q     <= '0;
            mem_y_q     <= '0;
            land_done_q <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values computed above.
            state_q     <= state_d;
            k_q         <= k_d;
            x_q         <= x_d;
            y_q         <= y_d;
            border_q    <= border_d;
            busy_q      <= busy_d;
            mem_we_q    <= mem_we_d;
            mem_x_q     <= mem_x_d;
            mem_y_q     <= mem_y_d;
            land_done_q <= land_done_d;
            game_over_q <= game_over_d;
        end
    end

    assign rho_x     = pack_cells(x_q);
    assign rho_y     = pack_cells(y_q);
    assign busy      = busy_q;
    assign mem_we    = mem_we_q;
    assign mem_x     = mem_x_q;
    assign mem_y     = mem_y_q;
    assign land_done = land_done_q;
    assign game_over = game_over_q;

    for (genvar c = 0; c < MEM_WIDTH; c++) begin : g_border
        assign border[(MEM_WIDTH-1-c)*WIDTH +: WIDTH] = border_q[c];
    end

endmodule

// File: tb/tb_figure_state_reg.sv
// Directed bench for figure_state_reg: board writes are checked against a
// scoreboard queue filled when a landing is requested.
module tb_figure_state_reg;
    import tetris_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        act_valid = 1'b0;
    logic [7:0]  action = 8'd0;
    logic        is_move = 1'b0;
    logic        is_load_fig = 1'b0;
    logic [31:0] rho_x, rho_y;
    logic [79:0] border;
    logic        busy, mem_we, land_done, game_over;
    logic [7:0]  mem_x, mem_y;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
    } wr_t;

    wr_t exp_q[$];
    int  bexp[10];
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    figure_state_reg dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .act_valid   (act_valid),
        .action      (action),
        .is_move     (is_move),
        .is_load_fig (is_load_fig),
        .rho_x       (rho_x),
        .rho_y       (rho_y),
        .border      (border),
        .busy        (busy),
        .mem_we      (mem_we),
        .mem_x       (mem_x),
        .mem_y       (mem_y),
        .land_done   (land_done),
        .game_over   (game_over)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] p4(input int a, input int b, input int c, input int d);
        return {a[7:0], b[7:0], c[7:0], d[7:0]};
    endfunction

    function automatic logic [31:0] rep(input int v);
        return p4(v, v, v, v);
    endfunction

    function automatic logic [79:0] bpack();
        logic [79:0] r;
        for (int c = 0; c < 10; c++) r[(9-c)*8 +: 8] = bexp[c][7:0];
        return r;
    endfunction

    // One clock; any board write seen after the edge is popped from the scoreboard.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        if (mem_we) begin
            check("wr_pending", 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("mem_xy", {mem_x, mem_y}, {e.x, e.y});
            end
        end
    endtask

    task automatic act(input logic [7:0] a, input logic mv, input logic ld);
        act_valid   = 1'b1;
        action      = a;
        is_move     = mv;
        is_load_fig = ld;
        tick();
        act_valid   = 1'b0;
        action      = 8'd0;
        is_move     = 1'b0;
        is_load_fig = 1'b0;
    endtask

    task automatic land_vertical(input int x, input int y0);
        for (int i = 0; i < 4; i++) exp_q.push_back('{x: x[7:0], y: 8'(y0 + i)});
        act(ACT_DOWN, 1'b0, 1'b0);
        check("land_busy", busy, 1);
        act(ACT_ROTR, 1'b1, 1'b1);
        tick();
        tick();
        check("land_done_early", land_done, 0);
        tick();
        check("land_done", land_done, 1);
        check("land_busy_clr", busy, 0);
        check("land_we_clr", mem_we, 0);
        if (y0 < bexp[x]) bexp[x] = y0;
        check("land_border", border, bpack());
    endtask

    initial begin
        for (int c = 0; c < 10; c++) bexp[c] = 20;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rho_x", rho_x, 0);
        check("rst_rho_y", rho_y, 0);
        check("rst_border", border, bpack());
        check("rst_flags", {busy, mem_we, land_done, game_over}, 0);
        check("rst_mem_xy", {mem_x, mem_y}, 0);
        rst_n = 1'b1;

        act(ACT_DOWN, 1'b1, 1'b0);
        check("idle_ignore", rho_y, 0);

        act(ACT_LOAD, 1'b0, 1'b1);
        check("spawn_x", rho_x, rep(4));
        check("spawn_y", rho_y, p4(0, 1, 2, 3));
        check("spawn_border", border, bpack());

        repeat (3) act(ACT_DOWN, 1'b1, 1'b0);
        check("down3_y", rho_y, p4(3, 4, 5, 6));
        act(ACT_RIGHT, 1'b1, 1'b0);
        check("right_x", rho_x, rep(5));

        repeat (3) act(ACT_LEFT, 1'b1, 1'b0);
        repeat (2) act(ACT_DOWN, 1'b1, 1'b0);
        check("pre_rot_x", rho_x, rep(2));
        check("pre_rot_y", rho_y, p4(5, 6, 7, 8));
        act(ACT_ROTR, 1'b1, 1'b0);
        check("rot_v_x", rho_x, p4(5, 4, 3, 2));
        check("rot_v_y", rho_y, rep(8));
        act(ACT_ROTR, 1'b1, 1'b0);
        check("rot_h_x", rho_x, rep(5));
        check("rot_h_y", rho_y, p4(8, 9, 10, 11));

        act(ACT_LEFT, 1'b0, 1'b0);
        act(ACT_RIGHT, 1'b0, 1'b0);
        act(ACT_ROTR, 1'b0, 1'b0);
        act(8'd5, 1'b1, 1'b0);
        act(ACT_LOAD, 1'b1, 1'b1);
        check("illegal_x", rho_x, rep(5));
        check("illegal_y", rho_y, p4(8, 9, 10, 11));

        repeat (5) act(ACT_LEFT, 1'b1, 1'b0);
        repeat (8) act(ACT_DOWN, 1'b1, 1'b0);
        check("bottom_x", rho_x, rep(0));
        check("bottom_y", rho_y, p4(16, 17, 18, 19));
        land_vertical(0, 16);
        check("commit_hold_x", rho_x, rep(0));
        check("commit_hold_y", rho_y, p4(16, 17, 18, 19));
        tick();
        check("land_done_pulse", land_done, 0);

        act(ACT_LOAD, 1'b0, 1'b1);
        repeat (4) act(ACT_DOWN, 1'b1, 1'b0);
        land_vertical(4, 4);
        act(ACT_LOAD, 1'b0, 1'b1);
        check("border4_alive", game_over, 0);
        check("border4_spawn", rho_y, p4(0, 1, 2, 3));
        repeat (3) act(ACT_DOWN, 1'b1, 1'b0);
        land_vertical(4, 3);
        act(ACT_LOAD, 1'b0, 1'b1);
        check("game_over_set", game_over, 1);
        act(ACT_DOWN, 1'b1, 1'b0);
        act(ACT_LOAD, 1'b0, 1'b1);
        tick();
        check("over_sticky", game_over, 1);
        check("over_hold_y", rho_y, p4(0, 1, 2, 3));
        check("over_quiet", {busy, mem_we}, 0);

        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) bexp[c] = 20;
        check("rst2_over_clr", game_over, 0);
        check("rst2_border", border, bpack());

        act(ACT_LOAD, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) exp_q.push_back('{x: 8'd4, y: 8'(i)});
        act(ACT_DOWN, 1'b0, 1'b0);
        tick();
        check("mid_commit_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_border", border, bpack());
        check("mid_rst_flags", {busy, mem_we, land_done}, 0);
        check("mid_rst_rho", rho_x, 0);
        exp_q.delete();
        #2;
        rst_n = 1'b1;
        tick();
        check("post_rst_quiet", {busy, mem_we}, 0);
        act(ACT_LOAD, 1'b0, 1'b1);
        check("post_rst_spawn", rho_x, rep(4));
        check("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
